// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the external interrupt controller.
package irq_pkg;

  localparam int unsigned NUM_IRQ  = 4;
  localparam int unsigned IRQ_ID_W = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: 2-flop synchronizer followed by a registered rising-edge detector.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic irq_line,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronize the async line, then keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= irq_line;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // High for the single cycle after the synchronized line goes 0->1.
  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: latches line events, prioritizes enabled ones
// (index 0 highest) and runs the request/acknowledge/return handshake with the core.
module ext_irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ = irq_pkg::NUM_IRQ
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                ext_iack,
  input  logic                eret,
  input  logic                en_we,
  input  logic [NUM_IRQ-1:0]  en_wdata,
  output logic                ext_irq,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic [NUM_IRQ-1:0]  pending,
  output logic                in_service
);

  irq_state_t          state_q;
  logic [NUM_IRQ-1:0]  pending_q;
  logic [NUM_IRQ-1:0]  enable_q;
  logic [IRQ_ID_W-1:0] irq_id_q;
  logic                ext_irq_q;
  logic                in_service_q;

  logic [NUM_IRQ-1:0]  ev;
  logic [NUM_IRQ-1:0]  req_vec;
  logic [NUM_IRQ-1:0]  clr;
  logic [IRQ_ID_W-1:0] sel_id;
  logic                sel_found;
  logic                ack_fire;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    irq_sync_edge u_sync (
      .clk      (clk),
      .reset    (reset),
      .irq_line (irq_in[g]),
      .rise     (ev[g])
    );
  end

  assign req_vec  = pending_q & enable_q;
  assign ack_fire = (state_q == REQ) && ext_iack;

  // Lowest set index of the enabled pending lines wins.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!sel_found && req_vec[i]) begin
        sel_id    = IRQ_ID_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Acknowledge clears only the line being requested.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = ack_fire && (irq_id_q == IRQ_ID_W'(i));
    end
  end

  // Pending latch; a new event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | ev;
    end
  end

  // Enable register, written by the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= '0;
    end else if (en_we) begin
      enable_q <= en_wdata;
    end
  end

  // Request/service FSM with registered outputs; irq_id is frozen outside IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_id_q     <= '0;
      ext_irq_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_vec) begin
            state_q   <= REQ;
            irq_id_q  <= sel_id;
            ext_irq_q <= 1'b1;
          end
        end
        REQ: begin
          if (ext_iack) begin
            state_q      <= SERVICE;
            ext_irq_q    <= 1'b0;
            in_service_q <= 1'b1;
          end
        end
        SERVICE: begin
          if (eret) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          ext_irq_q    <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign ext_irq    = ext_irq_q;
  assign irq_id     = irq_id_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed self-checking bench for ext_irq_ctrl.
module tb_ext_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       ext_iack;
  logic       eret;
  logic       en_we;
  logic [3:0] en_wdata;
  logic       ext_irq;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic       in_service;

  int total = 0;
  int bad   = 0;

  ext_irq_ctrl #(.NUM_IRQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .ext_iack   (ext_iack),
    .eret       (eret),
    .en_we      (en_we),
    .en_wdata   (en_wdata),
    .ext_irq    (ext_irq),
    .irq_id     (irq_id),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_en(input logic [3:0] val);
    en_we    = 1'b1;
    en_wdata = val;
    tick();
    en_we    = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    irq_in   = '0;
    ext_iack = 1'b0;
    eret     = 1'b0;
    en_we    = 1'b0;
    en_wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ext_irq", 32'(ext_irq), 32'h0);
    chk("rst_irq_id", 32'(irq_id), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_in_service", 32'(in_service), 32'h0);

    // Single event on line 2.
    write_en(4'b0100);
    irq_in[2] = 1'b1;
    tick();
    chk("single_e1_pending", 32'(pending), 32'h0);
    tick();
    chk("single_e2_pending", 32'(pending), 32'h0);
    tick();
    chk("single_e3_pending", 32'(pending), 32'h4);
    chk("single_e3_ext_irq", 32'(ext_irq), 32'h0);
    tick();
    chk("single_e4_ext_irq", 32'(ext_irq), 32'h1);
    chk("single_e4_irq_id", 32'(irq_id), 32'h2);
    ext_iack = 1'b1;
    tick();
    ext_iack = 1'b0;
    chk("single_ack_in_service", 32'(in_service), 32'h1);
    chk("single_ack_ext_irq", 32'(ext_irq), 32'h0);
    chk("single_ack_pending", 32'(pending), 32'h0);
    chk("single_ack_irq_id", 32'(irq_id), 32'h2);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("single_eret_in_service", 32'(in_service), 32'h0);
    tick();
    chk("single_idle_ext_irq", 32'(ext_irq), 32'h0);
    irq_in[2] = 1'b0;

    // Priority: lines 3 and 1 together; stray eret in REQ and stray ack in SERVICE.
    write_en(4'b1111);
    irq_in = 4'b1010;
    tick();
    tick();
    tick();
    chk("prio_pending", 32'(pending), 32'ha);
    tick();
    chk("prio_first_ext_irq", 32'(ext_irq), 32'h1);
    chk("prio_first_id", 32'(irq_id), 32'h1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("prio_stray_eret_ext_irq", 32'(ext_irq), 32'h1);
    chk("prio_stray_eret_id", 32'(irq_id), 32'h1);
    ext_iack = 1'b1;
    tick();
    chk("prio_ack1_pending", 32'(pending), 32'h8);
    chk("prio_ack1_in_service", 32'(in_service), 32'h1);
    tick();
    ext_iack = 1'b0;
    chk("prio_stray_ack_pending", 32'(pending), 32'h8);
    chk("prio_stray_ack_in_service", 32'(in_service), 32'h1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("prio_eret_ext_irq", 32'(ext_irq), 32'h0);
    chk("prio_eret_in_service", 32'(in_service), 32'h0);
    tick();
    chk("prio_second_ext_irq", 32'(ext_irq), 32'h1);
    chk("prio_second_id", 32'(irq_id), 32'h3);
    ext_iack = 1'b1;
    tick();
    ext_iack = 1'b0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("prio_done_pending", 32'(pending), 32'h0);
    irq_in = '0;

    // Masking: event latches with enable off; enabling releases the request.
    write_en(4'b0000);
    irq_in[0] = 1'b1;
    tick();
    tick();
    tick();
    chk("mask_pending", 32'(pending), 32'h1);
    chk("mask_ext_irq_e3", 32'(ext_irq), 32'h0);
    tick();
    chk("mask_ext_irq_e4", 32'(ext_irq), 32'h0);
    write_en(4'b0001);
    chk("mask_write_edge_ext_irq", 32'(ext_irq), 32'h0);
    tick();
    chk("mask_enabled_ext_irq", 32'(ext_irq), 32'h1);
    chk("mask_enabled_id", 32'(irq_id), 32'h0);
    ext_iack = 1'b1;
    tick();
    ext_iack = 1'b0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    chk("mask_no_reevent_pending", 32'(pending), 32'h0);
    irq_in[0] = 1'b0;

    // Collision: re-event on line 2 detected on the same edge as its acknowledge.
    write_en(4'b0100);
    irq_in[2] = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("coll_req_id", 32'(irq_id), 32'h2);
    irq_in[2] = 1'b0;
    tick();
    tick();
    tick();
    irq_in[2] = 1'b1;
    tick();
    tick();
    ext_iack = 1'b1;
    tick();
    ext_iack = 1'b0;
    chk("coll_in_service", 32'(in_service), 32'h1);
    chk("coll_pending", 32'(pending), 32'h4);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    chk("coll_rereq_ext_irq", 32'(ext_irq), 32'h1);
    chk("coll_rereq_id", 32'(irq_id), 32'h2);
    ext_iack = 1'b1;
    tick();
    ext_iack = 1'b0;
    irq_in = 4'b1010;
    tick();
    tick();
    tick();
    chk("rstsvc_pending", 32'(pending), 32'ha);
    chk("rstsvc_in_service", 32'(in_service), 32'h1);

    // Reset mid-service beats concurrent writes, ack, eret and held lines.
    reset    = 1'b1;
    en_we    = 1'b1;
    en_wdata = 4'b1111;
    ext_iack = 1'b1;
    eret     = 1'b1;
    tick();
    reset    = 1'b0;
    en_we    = 1'b0;
    chk("rstsvc_ext_irq", 32'(ext_irq), 32'h0);
    chk("rstsvc_irq_id", 32'(irq_id), 32'h0);
    chk("rstsvc_pending0", 32'(pending), 32'h0);
    chk("rstsvc_in_service0", 32'(in_service), 32'h0);
    tick();
    ext_iack = 1'b0;
    eret     = 1'b0;
    chk("stray_in_service", 32'(in_service), 32'h0);
    chk("stray_ext_irq", 32'(ext_irq), 32'h0);
    chk("held_e1_pending", 32'(pending), 32'h0);
    tick();
    chk("held_e2_pending", 32'(pending), 32'h0);
    tick();
    chk("held_e3_pending", 32'(pending), 32'ha);
    tick();
    chk("held_enable_cleared_ext_irq", 32'(ext_irq), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
